mux_rr_arbiter_4x1: RTL and testbench
=====================================

// Module: mux_rr_arbiter_4x1
// PURPOSE
//  Shares one N-bit 4:1 data mux between four valid/ready requesters using round-robin arbitration.
//  The arbiter picks a winner, steers the mux select to it, and registers the result into a single output holding stage.
//  An optional burst hold lets the current owner keep the grant for up to BURST consecutive beats.
//  Sits between producer channels and a single shared downstream consumer.
// PARAMETERS
//  N      3  data width per requester, in bits
//  BURST  1  maximum consecutive beats granted to one owner (must be >= 1; 1 = pure round-robin)
// PORTS
//  clk        in   1    single clock; all state updates on the rising edge
//  rst        in   1    synchronous reset, active-high
//  req_valid  in   4    requester i has data
//  req_data   in   4*N  requester i data at bits [i*N +: N]
//  req_ready  out  4    one-hot; the beat from requester i is accepted this cycle
//  out_valid  out  1    output holding register is full
//  out_data   out  N    held data
//  out_src    out  2    index of the requester that supplied out_data
//  out_ready  in   1    consumer takes out_data this cycle
// BEHAVIOUR
//  - Reset (rst=1 at an edge): out_valid=0, out_data=0, out_src=0, last=3, cnt=0, state=IDLE.
//    While rst=1, req_ready=0. Reset mid-transfer drops the held beat; no beat is accepted.
//  - State: IDLE (holding register empty) or FULL (out_valid=1).
//  - Accept opportunity: acc_en = (state==IDLE) | out_ready.
//  - Winner selection (combinational, evaluated every cycle):
//    - If req_valid[last] and 0 < cnt < BURST, the winner is last (burst hold).
//    - Otherwise the winner is the first i with req_valid[i], scanning last+1, last+2, ... (mod 4, wraps 3->0).
//  - req_ready[w] = acc_en & any(req_valid) & ~rst, for winner w only; all other bits are 0.
//  - On an acceptance edge:
//    - out_data <= req_data[w] via the mux (select = w); out_src <= w; out_valid <= 1; state <= FULL.
//    - cnt <= (w==last) ? cnt+1 : 1, saturating at BURST; last <= w.
//  - FULL, out_ready=1, no request: out_valid <= 0; state <= IDLE; last and cnt hold.
//  - FULL, out_ready=0: out_data, out_src and out_valid stay stable; req_ready=0 (backpressure).
//  - FULL, out_ready=1, with a request: drain and accept on the same edge. Back-to-back throughput is 1 beat/clock.
//  - Latency: a beat accepted at edge k is presented with out_valid=1 from edge k until its out_ready edge.
//  - A requester deasserting valid mid-burst ends the burst. The next pick rotates from last+1.
//  - The output never depends combinationally on out_ready, except req_ready.
//  - Consistency rule: if req_ready[i] is high, req_valid[i] is high.
// STRUCTURE
//  - Shared header mux_arb_defs.vh holds the state encodings (ST_IDLE=1'b0, ST_FULL=1'b1) and the requester count (NREQ=4).
//  - Instantiate the team block mux_4x1_nbit #(.n(N)) as the sole sub-module: w0..w3 = req_data slices, s = winner index.
//  - The arbiter logic (priority rotate, burst counter, holding register) stays in this module.
// TESTING (N=8)
//  1. Reset -> after rst=1 for 2 clk: out_valid=0, out_data=0, out_src=0, req_ready=0000.
//     First request req_valid=1111 -> req_ready=0001 (priority starts at 0 from last=3).
//  2. BURST=1, req_valid=1111, out_ready=1 held, data 8'hA0..A3 -> out_src 0,1,2,3,0 on consecutive clocks.
//     out_data follows A0,A1,A2,A3,A0; no idle cycles.
//  3. BURST=2, req_valid=0101 held, out_ready=1 -> out_src sequence 0,0,2,2,0,0.
//     Requester 0 drops valid after 1 beat -> next winner is 2 immediately.
//  4. Backpressure: beat 8'h5C held from src=1, out_ready=0 for 3 clk -> out_data=5C and out_valid=1 stable.
//     req_ready=0000 for all 3 cycles; out_ready=1 -> the next winner is accepted on the same edge.
//  5. Wrap and idle: last=3, only req_valid[2]=1 -> winner 2.
//     Drain with no requests -> out_valid=0, state=IDLE, last=2 retained.
//  6. Reset mid-burst (FULL, out_valid=1) -> one edge later out_valid=0, last=3, cnt=0; the held beat is not re-presented.

Source files
------------

// File: rtl/mux_rr_arbiter_4x1_pkg.sv
// Shared definitions for the round-robin 4:1 mux arbiter: state encoding,
// requester count and the rotating-priority pick.
package mux_rr_arbiter_4x1_pkg;

  localparam int NREQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // First valid requester after `last`, wrapping 3->0; `last` itself has lowest priority.
  function automatic logic [1:0] rr_pick(input logic [NREQ-1:0] valid, input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last + 2'd1;
    for (int k = NREQ; k >= 1; k--) begin
      idx = last + 2'(k);
      if (valid[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_4x1_if.sv
// Requester-side and consumer-side handshake bundle of the shared mux arbiter.
interface mux_rr_arbiter_4x1_if
  import mux_rr_arbiter_4x1_pkg::*;
#(
  parameter int N = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic [N-1:0]      out_data;
  logic [1:0]        out_src;
  logic              out_ready;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/mux_rr_arbiter_4x1_mux.sv
// Team n-bit 4:1 data mux steered by a 2-bit select.
module mux_4x1_nbit #(
  parameter int n = 3
) (
  input  logic [n-1:0] w0,
  input  logic [n-1:0] w1,
  input  logic [n-1:0] w2,
  input  logic [n-1:0] w3,
  input  logic [1:0]   s,
  output logic [n-1:0] f
);
  always_comb begin
    // NOTE: assign a default first so no path through the block can infer a latch.
    f = '0;
    case (s)
      2'd0: f = w0;
      2'd1: f = w1;
      2'd2: f = w2;
      2'd3: f = w3;
      default: f = '0;
    endcase
  end
endmodule

// File: rtl/mux_rr_arbiter_4x1.sv
// Round-robin arbiter with optional burst hold sharing one 4:1 mux,
// feeding a single output holding register.
module mux_rr_arbiter_4x1
  import mux_rr_arbiter_4x1_pkg::*;
#(
  parameter int N     = 3,
  parameter int BURST = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_rr_arbiter_4x1_if.slave bus
);
  localparam int             CW      = $clog2(BURST + 1);
  localparam logic [CW-1:0]  BURST_C = CW'(BURST);

  state_e          state_q, state_d;
  logic [1:0]      last_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    data_q;
  logic [1:0]      src_q;
  logic [1:0]      winner;
  logic            acc_en, hold, accept;
  logic [NREQ-1:0] req_ready;
  logic [N-1:0]    mux_y;

  mux_4x1_nbit #(.n(N)) u_mux (
    .w0 (bus.req_data[0*N +: N]),
    .w1 (bus.req_data[1*N +: N]),
    .w2 (bus.req_data[2*N +: N]),
    .w3 (bus.req_data[3*N +: N]),
    .s  (winner),
    .f  (mux_y)
  );

  // Burst hold only while the owner still asks and has beats left in its budget.
  always_comb begin
    acc_en    = (state_q == ST_IDLE) | bus.out_ready;
    hold      = bus.req_valid[last_q] && (cnt_q != '0) && (cnt_q < BURST_C);
    winner    = hold ? last_q : rr_pick(bus.req_valid, last_q);
    accept    = acc_en & (|bus.req_valid) & ~rst;
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
    if (winner == last_q) cnt_d = (cnt_q == BURST_C) ? cnt_q : cnt_q + 1'b1;
    else                  cnt_d = CW'(1);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_FULL;
      ST_FULL: if (bus.out_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= mux_y;
        src_q  <= winner;
        last_q <= winner;
        cnt_q  <= cnt_d;
      end
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_mux_rr_arbiter_4x1.sv
// Self-checking bench: two arbiters (BURST=1 and BURST=2) on shared random stimulus,
// compared each cycle against a behavioural model, plus directed literal checks.
module tb_mux_rr_arbiter_4x1;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter_4x1_if #(.N(8)) if0 ();
  mux_rr_arbiter_4x1_if #(.N(8)) if1 ();

  assign if0.req_valid = req_valid;
  assign if0.req_data  = req_data;
  assign if0.out_ready = out_ready;
  assign if1.req_valid = req_valid;
  assign if1.req_data  = req_data;
  assign if1.out_ready = out_ready;

  mux_rr_arbiter_4x1 #(.N(8), .BURST(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  mux_rr_arbiter_4x1 #(.N(8), .BURST(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  logic [3:0] rr [2];
  logic       ov [2];
  logic [7:0] od [2];
  logic [1:0] os [2];
  assign rr[0] = if0.req_ready;
  assign ov[0] = if0.out_valid;
  assign od[0] = if0.out_data;
  assign os[0] = if0.out_src;
  assign rr[1] = if1.req_ready;
  assign ov[1] = if1.out_valid;
  assign od[1] = if1.out_data;
  assign os[1] = if1.out_src;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: holding register plus owner/beat-count bookkeeping.
  int         bursts [2] = '{1, 2};
  bit         model_ok = 1'b0;
  bit         m_full [2];
  logic [7:0] m_data [2];
  int         m_src  [2];
  int         m_last [2];
  int         m_cnt  [2];

  function automatic int pick(int b, logic [3:0] v, int last, int cnt);
    if (v[last] && cnt > 0 && cnt < b) return last;
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(int u);
    int w;
    w = pick(bursts[u], req_valid, m_last[u], m_cnt[u]);
    if (rst || w < 0 || !(!m_full[u] || out_ready)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      int w;
      if (rst) begin
        m_full[u] <= 1'b0;
        m_data[u] <= 8'h00;
        m_src[u]  <= 0;
        m_last[u] <= 3;
        m_cnt[u]  <= 0;
      end else begin
        w = pick(bursts[u], req_valid, m_last[u], m_cnt[u]);
        if ((!m_full[u] || out_ready) && w >= 0) begin
          m_data[u] <= req_data[w*8 +: 8];
          m_src[u]  <= w;
          m_full[u] <= 1'b1;
          m_last[u] <= w;
          m_cnt[u]  <= (w == m_last[u]) ? ((m_cnt[u] + 1 > bursts[u]) ? bursts[u] : m_cnt[u] + 1) : 1;
        end else if (m_full[u] && out_ready) begin
          m_full[u] <= 1'b0;
        end
      end
    end
    if (rst) model_ok <= 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("u%0d req_ready", u), 32'(rr[u]), 32'(exp_ready(u)));
        check($sformatf("u%0d out_valid", u), 32'(ov[u]), 32'(m_full[u]));
        check($sformatf("u%0d out_data", u),  32'(od[u]), 32'(m_data[u]));
        check($sformatf("u%0d out_src", u),   32'(os[u]), 32'(m_src[u]));
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req_valid = 4'b0000; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_src [6] = '{0, 0, 2, 2, 0, 0};
    rst = 1'b1; req_valid = 4'b0000; req_data = '0; out_ready = 1'b0;

    // Reset with all requesters asking: nothing accepted, outputs cleared.
    req_valid = 4'b1111;
    step(); step();
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst u%0d out_valid", u), 32'(ov[u]), 32'd0);
      check($sformatf("rst u%0d out_data", u),  32'(od[u]), 32'd0);
      check($sformatf("rst u%0d out_src", u),   32'(os[u]), 32'd0);
      check($sformatf("rst u%0d req_ready", u), 32'(rr[u]), 32'b0000);
    end
    rst = 1'b0; #1;
    check("first grant u0", 32'(rr[0]), 32'b0001);
    check("first grant u1", 32'(rr[1]), 32'b0001);

    // Pure round-robin streaming.
    req_data = 32'hA3A2A1A0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr beat%0d src", i),  32'(os[0]), 32'(i % 4));
      check($sformatf("rr beat%0d data", i), 32'(od[0]), 32'(8'hA0 + 8'(i % 4)));
      check($sformatf("rr beat%0d valid", i), 32'(ov[0]), 32'd1);
    end

    // Burst of two alternating between requesters 0 and 2.
    do_reset();
    req_valid = 4'b0101; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check($sformatf("burst beat%0d src", i), 32'(os[1]), 32'(exp_src[i]));
    end
    do_reset();
    req_valid = 4'b0101; out_ready = 1'b1;
    step();
    check("burst first src", 32'(os[1]), 32'd0);
    req_valid = 4'b0100;
    step();
    check("burst drop src", 32'(os[1]), 32'd2);

    // Backpressure holds the beat steady and blocks all grants.
    do_reset();
    req_data = 32'h33225C11; req_valid = 4'b0010; out_ready = 1'b0;
    step();
    check("bp accept data", 32'(od[0]), 32'h5C);
    check("bp accept src",  32'(os[0]), 32'd1);
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("bp cyc%0d data", i),   32'(od[0]), 32'h5C);
      check($sformatf("bp cyc%0d valid", i),  32'(ov[0]), 32'd1);
      check($sformatf("bp cyc%0d ready0", i), 32'(rr[0]), 32'b0000);
      check($sformatf("bp cyc%0d ready1", i), 32'(rr[1]), 32'b0000);
    end
    out_ready = 1'b1; #1;
    check("bp release ready0", 32'(rr[0]), 32'b0100);
    check("bp release ready1", 32'(rr[1]), 32'b0010);
    step();
    check("bp next src0",  32'(os[0]), 32'd2);
    check("bp next data0", 32'(od[0]), 32'h22);
    check("bp next src1",  32'(os[1]), 32'd1);

    // Wrap from last=3 and drain to idle; last is retained.
    do_reset();
    req_valid = 4'b0100; out_ready = 1'b1;
    step();
    check("wrap src", 32'(os[0]), 32'd2);
    req_valid = 4'b0000;
    step();
    check("drain valid", 32'(ov[0]), 32'd0);
    req_valid = 4'b1111; #1;
    check("last kept ready0", 32'(rr[0]), 32'b1000);
    check("last kept ready1", 32'(rr[1]), 32'b0100);

    // Reset while full drops the held beat.
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1;
    step();
    check("pre-reset valid", 32'(ov[0]), 32'd1);
    rst = 1'b1; #1;
    check("in-reset ready", 32'(rr[0]), 32'b0000);
    step();
    check("post-reset valid0", 32'(ov[0]), 32'd0);
    check("post-reset valid1", 32'(ov[1]), 32'd0);
    check("post-reset data0",  32'(od[0]), 32'd0);
    rst = 1'b0; #1;
    check("post-reset ready0", 32'(rr[0]), 32'b0001);
    check("post-reset ready1", 32'(rr[1]), 32'b0001);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_data  = $urandom;
      out_ready = ($urandom % 4) != 0;
      rst       = ($urandom % 128) == 0;
      step();
    end
    rst = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
